// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 hex keypad row scanner with column debounce and a key-event FIFO.
// Row strobes and column returns are active-low; accepted presses are queued as hex codes.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYC   = 4,
    parameter int DEBOUNCE_CNT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    col,
    output logic [3:0]                    row,
    output logic                          key_valid,
    output logic [3:0]                    key_hex,
    input  logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SETTLE_CYC);
    // Indexed by {row, low column}; nibble 0 is (r0,c0), nibble 15 is (r3,c3).
    localparam logic [63:0] KEY_MAP = 64'h147F_2580_369E_ABCD;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t          state_q;
    logic [3:0]      sync_q;
    logic [3:0]      col_s_q;
    logic [1:0]      r_q;
    logic [SW-1:0]   set_q;
    logic [7:0]      deb_q;
    logic [3:0]      pat_q;
    logic [3:0]      hex_q;
    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wp_q;
    logic [AW-1:0]   rp_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            ovf_q;
    logic [1:0]      c_idx;
    logic            one_low;
    logic            match;
    logic            deb_done;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr;

    assign c_idx    = !col_s_q[0] ? 2'd0 : !col_s_q[1] ? 2'd1 : !col_s_q[2] ? 2'd2 : 2'd3;
    assign one_low  = $onehot(~col_s_q);
    assign match    = col_s_q == pat_q;
    assign deb_done = deb_q == 8'(DEBOUNCE_CNT - 1);
    assign push     = state_q == DEB_PRESS && match && deb_done;
    assign pop      = key_valid && key_ready;
    assign full     = cnt_q == CW'(FIFO_DEPTH);
    // A push into a full queue still lands when the head leaves in the same cycle.
    assign wr       = push && (!full || pop);
    assign cnt_d    = cnt_q + CW'(wr) - CW'(pop);

    assign row        = ~(4'b0001 << r_q);
    assign key_valid  = cnt_q != '0;
    assign key_hex    = mem_q[rp_q];
    assign fifo_count = cnt_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 4'hF;
            col_s_q <= 4'hF;
        end else begin
            sync_q  <= col;
            col_s_q <= sync_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN;
            r_q     <= '0;
            set_q   <= '0;
            deb_q   <= '0;
            pat_q   <= 4'hF;
            hex_q   <= '0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (set_q == SW'(SETTLE_CYC - 1)) begin
                        set_q <= '0;
                        if (one_low) begin
                            pat_q   <= col_s_q;
                            hex_q   <= KEY_MAP[{r_q, c_idx, 2'b00} +: 4];
                            deb_q   <= '0;
                            state_q <= DEB_PRESS;
                        end else begin
                            r_q <= r_q + 2'd1;
                        end
                    end else begin
                        set_q <= set_q + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (!match) begin
                        r_q     <= r_q + 2'd1;
                        state_q <= SCAN;
                    end else if (deb_done) begin
                        state_q <= HELD;
                    end else begin
                        deb_q <= deb_q + 8'd1;
                    end
                end
                HELD: begin
                    if (col_s_q == 4'hF) begin
                        deb_q   <= '0;
                        state_q <= DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (col_s_q != 4'hF) begin
                        state_q <= HELD;
                    end else if (deb_done) begin
                        r_q     <= r_q + 2'd1;
                        state_q <= SCAN;
                    end else begin
                        deb_q <= deb_q + 8'd1;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wp_q] <= hex_q;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_d;
            ovf_q <= (push && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench for keypad_scan_ctrl using a 16-key switch-matrix model.
module tb_keypad_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_hex;
    logic        key_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic [15:0] keys = '0;
    logic [3:0]  seen;
    int          n_cmp = 0;
    int          n_err = 0;

    keypad_scan_ctrl dut (
        .clk(clk), .rst(rst), .col(col), .row(row), .key_valid(key_valid),
        .key_hex(key_hex), .key_ready(key_ready), .fifo_count(fifo_count),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Closed switch (r,c) pulls column c low while row r is strobed.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
    end

    function automatic logic [3:0] rowv(input int r);
        return ~(4'b0001 << r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_all();
        keys = '0;
        tick(30);
    endtask

    task automatic press_wait(input int idx, input int cnt, input string tag);
        keys = '0;
        keys[idx] = 1'b1;
        for (int i = 0; i < 100 && fifo_count != 3'(cnt); i++) tick(1);
        check(tag, fifo_count, cnt);
        release_all();
    endtask

    // Returns on the first cycle the key's row is strobed, so the sample is 3 cycles later.
    task automatic arm_key(input int idx);
        logic [3:0] tgt;
        tgt = rowv(idx / 4);
        for (int i = 0; i < 40 && row == tgt; i++) tick(1);
        keys = '0;
        keys[idx] = 1'b1;
        for (int i = 0; i < 40 && row != tgt; i++) tick(1);
        check("arm_row", row, tgt);
    endtask

    task automatic pop_chk(input string tag, input logic [3:0] exp);
        check({tag, "_valid"}, key_valid, 1);
        check(tag, key_hex, exp);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
    endtask

    task automatic scan_seen(input string tag);
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            seen = seen | ~row;
            tick(1);
        end
        check(tag, seen, 4'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 20; k++) begin
            check("idle_row", row, rowv((k / 4) % 4));
            tick(1);
        end
        check("idle_valid", key_valid, 0);
        check("idle_count", fifo_count, 0);
        check("idle_hex", key_hex, 0);
        check("idle_ovf", overflow, 0);

        arm_key(15);
        tick(11);
        check("lat_pre", key_valid, 0);
        tick(1);
        check("lat_valid", key_valid, 1);
        check("lat_hex", key_hex, 4'h1);
        check("lat_cnt", fifo_count, 1);
        release_all();
        press_wait(0, 2, "d_cnt");
        check("d_head", key_hex, 4'h1);
        pop_chk("pop_1", 4'h1);
        pop_chk("pop_d", 4'hD);
        check("d_empty", fifo_count, 0);

        for (int i = 0; i < 20; i++) begin
            keys = (i % 2 == 0) ? 16'h0800 : 16'h0000;
            tick(3);
        end
        keys = '0;
        tick(10);
        check("bnc_cnt", fifo_count, 0);
        scan_seen("bnc_scan");
        press_wait(11, 1, "bnc_push");
        pop_chk("pop_2", 4'h2);

        keys = '0;
        keys[3] = 1'b1;
        for (int i = 0; i < 100 && fifo_count != 3'd1; i++) tick(1);
        tick(1000);
        keys[2] = 1'b1;
        tick(50);
        check("hold_cnt", fifo_count, 1);
        keys = '0;
        tick(20);
        scan_seen("hold_scan");
        check("hold_cnt2", fifo_count, 1);
        pop_chk("pop_a", 4'hA);

        press_wait(10, 1, "ov_1");
        press_wait(6, 2, "ov_2");
        press_wait(9, 3, "ov_3");
        press_wait(5, 4, "ov_4");
        keys = '0;
        keys[8] = 1'b1;
        for (int i = 0; i < 100 && !overflow; i++) tick(1);
        check("ovf_set", overflow, 1);
        check("ovf_cnt", fifo_count, 4);
        release_all();
        pop_chk("ov_pop5", 4'h5);
        pop_chk("ov_pop6", 4'h6);
        pop_chk("ov_pop8", 4'h8);
        pop_chk("ov_pop9", 4'h9);
        check("ov_empty", fifo_count, 0);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);

        press_wait(10, 1, "pp_1");
        press_wait(6, 2, "pp_2");
        press_wait(9, 3, "pp_3");
        press_wait(5, 4, "pp_4");
        arm_key(4);
        tick(11);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("pp_cnt", fifo_count, 4);
        check("pp_ovf", overflow, 0);
        release_all();
        pop_chk("pp_pop6", 4'h6);
        pop_chk("pp_pop8", 4'h8);
        pop_chk("pp_pop9", 4'h9);
        pop_chk("pp_pope", 4'hE);
        check("pp_empty", fifo_count, 0);

        press_wait(10, 1, "rs_pre");
        arm_key(15);
        tick(5);
        rst = 1'b1;
        #1;
        check("rs_row", row, 4'b1110);
        check("rs_valid", key_valid, 0);
        check("rs_cnt", fifo_count, 0);
        check("rs_hex", key_hex, 0);
        tick(2);
        keys = '0;
        rst = 1'b0;
        #1;
        check("rs_row0", row, 4'b1110);
        tick(4);
        check("rs_row1", row, 4'b1101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
